// File: rtl/val2_shift_pkg.sv
// Shared constants for the val2 shift sequencer: shift-type codes,
// FSM state encodings and the per-cycle step limit of the fast build.
package val2_shift_pkg;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   // Largest number of bit positions moved in one SHIFT cycle (fast build).
   localparam int MAX_STEP = 4;
   // Width of the step amount bus (holds 0..MAX_STEP).
   localparam int STEP_W   = 3;

endpackage

// File: rtl/val2_shift_step.sv
// Combinational single-step shifter: applies op to value by step bit
// positions (step is 1..MAX_STEP in use). LSL/LSR fill with zero, ASR
// replicates the sign bit, ROR wraps low bits into the top.
import val2_shift_pkg::*;

module val2_shift_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]  value_i,
   input  logic [1:0]        op_i,
   input  logic [STEP_W-1:0] step_i,
   output logic [WIDTH-1:0]  value_o
);

   logic signed [WIDTH-1:0] value_s;

   assign value_s = value_i;

   // Select the shifted value for the requested operation.
   always_comb begin
      value_o = value_i;
      case (op_i)
         SH_LSL:  value_o = value_i << step_i;
         SH_LSR:  value_o = value_i >> step_i;
         SH_ASR:  value_o = $unsigned(value_s >>> step_i);
         SH_ROR:  value_o = (value_i >> step_i) | (value_i << (WIDTH - int'(step_i)));
         default: value_o = value_i;
      endcase
   end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Iterative val2 generator for the EXE stage. A request is decoded on
// accept into a working value, a shift op and a remaining count; the
// SHIFT state then walks the value toward the result and DONE holds it
// until the consumer takes it.
// Build option: VAL2_FAST_SHIFT_EN -- when defined, each SHIFT cycle
// moves up to MAX_STEP bits instead of one; results are identical.
import val2_shift_pkg::*;

module val2_shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      rm,
   input  logic [11:0]      shift_operand,
   input  logic             imm,
   input  logic             load_store,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] val2,
   output logic             busy
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [WIDTH-1:0]    value_q, value_d;
   logic [1:0]          op_q, op_d;
   logic [STEP_W-1:0]   step;
   logic [WIDTH-1:0]    step_val;

`ifdef VAL2_FAST_SHIFT_EN
   // Move min(count, MAX_STEP) bits this cycle.
   always_comb begin
      step = (count_q >= CNT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : count_q[STEP_W-1:0];
   end
`else
   // Move exactly one bit per SHIFT cycle.
   always_comb begin
      step = STEP_W'(1);
   end
`endif

   val2_shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .value_i (value_q),
      .op_i    (op_q),
      .step_i  (step),
      .value_o (step_val)
   );

   // Next-state, decode-on-accept and per-cycle shift update.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      value_d = value_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (load_store) begin
                  value_d = WIDTH'(shift_operand);
                  op_d    = SH_LSL;
                  count_d = '0;
               end else if (imm) begin
                  value_d = WIDTH'(shift_operand[7:0]);
                  op_d    = SH_ROR;
                  count_d = CNT_W'({shift_operand[11:8], 1'b0});
               end else begin
                  value_d = rm;
                  op_d    = shift_operand[6:5];
                  count_d = CNT_W'(shift_operand[11:7]);
               end
               // A zero amount means no shift for every op, so skip SHIFT.
               state_d = (count_d == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            value_d = step_val;
            count_d = count_q - CNT_W'(step);
            if (count_d == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
      // Abort wins over everything, including a same-cycle accept.
      if (flush) begin
         state_d = ST_IDLE;
         count_d = '0;
      end
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Datapath registers; val2 is masked outside DONE so they need no reset.
   always_ff @(posedge clk) begin
      value_q <= value_d;
      op_q    <= op_d;
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign val2      = out_valid ? value_q : '0;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Self-checking bench for val2_shift_sequencer: golden shift model feeds
// a scoreboard of expected value and latency per accepted request.
module tb_val2_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] rm;
   logic [11:0] shift_operand;
   logic        imm;
   logic        load_store;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] val2;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] val;
      int          lat;
   } exp_t;

   exp_t sb[$];

   val2_shift_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .rm            (rm),
      .shift_operand (shift_operand),
      .imm           (imm),
      .load_store    (load_store),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .val2          (val2),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   function automatic int exp_latency(input int n);
      if (n == 0) return 1;
`ifdef VAL2_FAST_SHIFT_EN
      return (n + 3) / 4 + 1;
`else
      return n + 1;
`endif
   endfunction

   function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
      if (n == 0) return v;
      return (v >> n) | (v << (32 - n));
   endfunction

   function automatic exp_t model(input logic [31:0] r, input logic [11:0] so,
                                  input bit i, input bit ls);
      exp_t        e;
      int          n;
      logic [31:0] b;
      if (ls) begin
         e.val = {20'b0, so};
         n = 0;
      end else if (i) begin
         b = {24'b0, so[7:0]};
         n = 2 * int'(so[11:8]);
         e.val = ror32(b, n);
      end else begin
         n = int'(so[11:7]);
         case (so[6:5])
            2'b00:   e.val = r << n;
            2'b01:   e.val = r >> n;
            2'b10:   e.val = $unsigned($signed(r) >>> n);
            default: e.val = ror32(r, n);
         endcase
      end
      e.lat = exp_latency(n);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for one cycle (caller guarantees IDLE) and log its expectation.
   task automatic issue(input logic [31:0] r, input logic [11:0] so, input bit i, input bit ls);
      rm = r; shift_operand = so; imm = i; load_store = ls;
      in_valid = 1'b1;
      sb.push_back(model(r, so, i, ls));
      tick();
      in_valid = 1'b0;
      rm = 32'hDEAD_BEEF; shift_operand = 12'hFFF; imm = 1'b1; load_store = 1'b0;
   endtask

   // Cycles since accept until out_valid, bounded.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (val2 !== 32'h0) begin errors++; $display("FAIL reset_val2 got=%h exp=0", val2); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lsl();
      int   lat;
      exp_t e;
      issue(32'd5, 12'b0011_1000_0101, 1'b0, 1'b0);
      wait_valid(lat);
      e = sb.pop_front();
      checks++; if (val2 !== 32'h0000_0280 || val2 !== e.val) begin errors++; $display("FAIL lsl7_val got=%h exp=%h", val2, e.val); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL lsl7_latency got=%0d exp=%0d", lat, e.lat); end
      tick();
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL lsl7_return_idle in_ready=%b busy=%b exp 1/0", in_ready, busy); end
   endtask

   task automatic test_ops();
      logic [31:0] r_t  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h1234_5678, 32'hF000_000F, 32'h8765_4321};
      logic [11:0] so_t [6] = '{12'b0011_1010_0101, 12'b0011_1110_0101, 12'b0011_1100_0101,
                                12'b1111_1000_0000, 12'b1000_0110_0000, 12'b0000_0100_0000};
      int   lat;
      exp_t e;
      for (int k = 0; k < 6; k++) begin
         issue(r_t[k], so_t[k], 1'b0, 1'b0);
         wait_valid(lat);
         e = sb.pop_front();
         checks++; if (val2 !== e.val) begin errors++; $display("FAIL op%0d_val got=%h exp=%h", k, val2, e.val); end
         checks++; if (lat !== e.lat) begin errors++; $display("FAIL op%0d_latency got=%0d exp=%0d", k, lat, e.lat); end
         tick();
      end
   endtask

   task automatic test_imm_ls();
      bit          i_t  [3] = '{1'b1, 1'b1, 1'b1};
      bit          ls_t [3] = '{1'b0, 1'b1, 1'b0};
      logic [11:0] so_t [3] = '{12'b0011_1000_0101, 12'b0011_1000_0101, 12'hFAB};
      logic [31:0] fix  [2] = '{32'h1400_0002, 32'h0000_0385};
      int   lat;
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         issue(32'hFFFF_FFFF, so_t[k], i_t[k], ls_t[k]);
         wait_valid(lat);
         e = sb.pop_front();
         if (k < 2) begin
            checks++; if (val2 !== fix[k]) begin errors++; $display("FAIL imm_ls%0d_fixed got=%h exp=%h", k, val2, fix[k]); end
         end
         checks++; if (val2 !== e.val) begin errors++; $display("FAIL imm_ls%0d_val got=%h exp=%h", k, val2, e.val); end
         checks++; if (lat !== e.lat) begin errors++; $display("FAIL imm_ls%0d_latency got=%0d exp=%0d", k, lat, e.lat); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int   lat;
      int   bad;
      exp_t e;
      out_ready = 1'b0;
      issue(32'd5, 12'b0011_1000_0101, 1'b0, 1'b0);
      wait_valid(lat);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, e.lat); end
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         if (out_valid !== 1'b1 || val2 !== e.val || in_ready !== 1'b0) bad++;
         tick();
      end
      in_valid = 1'b0;
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
      checks++; if (out_valid !== 1'b1 || val2 !== e.val) begin errors++; $display("FAIL bp_still_valid ov=%b val=%h exp 1/%h", out_valid, val2, e.val); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release ov=%b busy=%b in_ready=%b exp 0/0/1", out_valid, busy, in_ready);
      end
   endtask

   task automatic test_flush();
      int   lat;
      int   seen;
      exp_t e;
      issue(32'd5, 12'b0011_1000_0101, 1'b0, 1'b0);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      void'(sb.pop_back());
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_idle busy=%b ov=%b in_ready=%b exp 0/0/1", busy, out_valid, in_ready);
      end
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_output valid_cycles=%0d exp=0", seen); end
      // Flush in the same cycle as an accept drops the request.
      rm = 32'd1; shift_operand = 12'b0000_1000_0000; imm = 1'b0; load_store = 1'b0;
      in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept busy=%b ov=%b exp 0/0", busy, out_valid); end
      issue(32'h8000_0001, 12'b0010_0010_0000, 1'b0, 1'b0);
      wait_valid(lat);
      e = sb.pop_front();
      checks++; if (val2 !== e.val) begin errors++; $display("FAIL flush_after_val got=%h exp=%h", val2, e.val); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL flush_after_latency got=%0d exp=%0d", lat, e.lat); end
      tick();
   endtask

   task automatic test_rst_mid();
      int   lat;
      exp_t e;
      issue(32'd5, 12'b0011_1000_0101, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(sb.pop_back());
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || val2 !== 32'h0) begin
         errors++; $display("FAIL rst_mid in_ready=%b ov=%b busy=%b val2=%h exp 1/0/0/0", in_ready, out_valid, busy, val2);
      end
      issue(32'hC000_0003, 12'b0001_0110_0000, 1'b0, 1'b0);
      wait_valid(lat);
      e = sb.pop_front();
      checks++; if (val2 !== e.val) begin errors++; $display("FAIL rst_after_val got=%h exp=%h", val2, e.val); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL rst_after_latency got=%0d exp=%0d", lat, e.lat); end
      tick();
      checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; rm = '0; shift_operand = '0;
      imm = 1'b0; load_store = 1'b0; flush = 1'b0; out_ready = 1'b1;
      test_reset();
      test_lsl();
      test_ops();
      test_imm_ls();
      test_backpressure();
      test_flush();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
